// File: rtl/ex_stage_if.sv
// Bundle between ID/EX (upstream) and the EX stage, plus the EX/MEM outputs.
interface ex_stage_if #(
  parameter int XLEN = 32
);
  logic            valid_ex;
  logic            flush_ex;
  logic [4:0]      ctrl_ex;
  logic [4:0]      alu_op;
  logic            alu_src;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm_ex;
  logic [XLEN-1:0] pc_ex;
  logic [XLEN-1:0] rd_ex;
  logic [4:0]      ctrl_mem;
  logic [XLEN-1:0] rd_mem;
  logic [XLEN-1:0] pc4_mem;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] write_data1;
  logic            stall_ex;

  // upstream side: drives the instruction, observes EX/MEM and stall
  modport master (
    output valid_ex, flush_ex, ctrl_ex, alu_op, alu_src,
           rs1_data, rs2_data, imm_ex, pc_ex, rd_ex,
    input  ctrl_mem, rd_mem, pc4_mem, alu_result, write_data1, stall_ex
  );

  // EX stage side
  modport slave (
    input  valid_ex, flush_ex, ctrl_ex, alu_op, alu_src,
           rs1_data, rs2_data, imm_ex, pc_ex, rd_ex,
    output ctrl_mem, rd_mem, pc4_mem, alu_result, write_data1, stall_ex
  );
endinterface

// File: rtl/ex_stage.sv
// RV32IM execute stage: operand select, single-cycle ALU/multiplier,
// 32-step restoring divider, and the EX/MEM pipeline register.
module ex_stage #(
  parameter int          XLEN    = 32,
  parameter int unsigned PC_STEP = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  ex_stage_if.slave bus
);

  localparam logic [XLEN-1:0] PC_INC = XLEN'(PC_STEP);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;
  localparam logic [4:0] OP_PASSB  = 5'd18;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // divider state
  logic [1:0]      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            div0_q, div0_d;

  // EX/MEM register
  logic [4:0]      ctrl_mem_q, ctrl_mem_d;
  logic [XLEN-1:0] rd_mem_q, rd_mem_d;
  logic [XLEN-1:0] pc4_mem_q, pc4_mem_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] write_data1_q, write_data1_d;

  logic [XLEN-1:0] op_a, op_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;
  logic            is_div;
  logic            mul_sa, mul_sb;
  logic signed [2*XLEN+1:0] mul_a, mul_b, prod;
  logic            stall;
  logic            unused_prod;

  assign op_a   = bus.rs1_data;
  assign op_b   = bus.alu_src ? bus.imm_ex : bus.rs2_data;
  assign shamt  = op_b[4:0];
  assign is_div = (bus.alu_op >= OP_DIV) && (bus.alu_op <= OP_REMU);

  // One shared 33x33 signed multiplier; operand signedness picks the MULH flavour.
  always_comb begin
    mul_sa = (bus.alu_op == OP_MULH) || (bus.alu_op == OP_MULHSU);
    mul_sb = (bus.alu_op == OP_MULH);
    mul_a  = {{(XLEN+2){mul_sa & op_a[XLEN-1]}}, op_a};
    mul_b  = {{(XLEN+2){mul_sb & op_b[XLEN-1]}}, op_b};
    prod   = mul_a * mul_b;
  end

  assign unused_prod = ^prod[2*XLEN+1:2*XLEN];

  // Single-cycle ALU result.
  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      OP_ADD:    alu_res = op_a + op_b;
      OP_SUB:    alu_res = op_a - op_b;
      OP_SLL:    alu_res = op_a << shamt;
      OP_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU:   alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_XOR:    alu_res = op_a ^ op_b;
      OP_SRL:    alu_res = op_a >> shamt;
      OP_SRA:    alu_res = $signed(op_a) >>> shamt;
      OP_OR:     alu_res = op_a | op_b;
      OP_AND:    alu_res = op_a & op_b;
      OP_MUL:    alu_res = prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  alu_res = prod[2*XLEN-1:XLEN];
      OP_PASSB:  alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end

  // Divider FSM and EX/MEM next-state; bubbles are all-zero.
  always_comb begin
    logic            sgn;
    logic            a_neg, b_neg;
    logic [XLEN:0]   rs, diff;
    logic [XLEN-1:0] q_fix, r_fix;

    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    is_rem_d      = is_rem_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    div0_d        = div0_q;
    ctrl_mem_d    = '0;
    rd_mem_d      = '0;
    pc4_mem_d     = '0;
    alu_result_d  = '0;
    write_data1_d = '0;
    stall         = 1'b0;

    sgn   = (bus.alu_op == OP_DIV) || (bus.alu_op == OP_REM);
    a_neg = sgn & op_a[XLEN-1];
    b_neg = sgn & op_b[XLEN-1];
    rs    = {rem_q, quo_q[XLEN-1]};
    diff  = rs - {1'b0, dvs_q};
    // Zero divisor: restoring division already leaves |A| as remainder,
    // only the quotient needs forcing. INT_MIN/-1 falls out naturally.
    q_fix = div0_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
    r_fix = neg_rem_q ? -rem_q : rem_q;

    case (state_q)
      S_IDLE: begin
        if (bus.valid_ex && is_div) begin
          stall     = 1'b1;
          state_d   = S_RUN;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = a_neg ? -op_a : op_a;
          dvs_d     = b_neg ? -op_b : op_b;
          is_rem_d  = (bus.alu_op == OP_REM) || (bus.alu_op == OP_REMU);
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (op_b == '0);
        end else if (bus.valid_ex) begin
          ctrl_mem_d    = bus.ctrl_ex;
          rd_mem_d      = bus.rd_ex;
          pc4_mem_d     = bus.pc_ex + PC_INC;
          alu_result_d  = alu_res;
          write_data1_d = bus.rs2_data;
        end
      end
      S_RUN: begin
        stall = 1'b1;
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rs[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_DONE;
      end
      S_DONE: begin
        // upstream held the divide instruction, so its tags are still live
        state_d       = S_IDLE;
        ctrl_mem_d    = bus.ctrl_ex;
        rd_mem_d      = bus.rd_ex;
        pc4_mem_d     = bus.pc_ex + PC_INC;
        alu_result_d  = is_rem_q ? r_fix : q_fix;
        write_data1_d = bus.rs2_data;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.flush_ex) begin
      state_d       = S_IDLE;
      stall         = 1'b0;
      ctrl_mem_d    = '0;
      rd_mem_d      = '0;
      pc4_mem_d     = '0;
      alu_result_d  = '0;
      write_data1_d = '0;
    end
  end

  // State and EX/MEM register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      is_rem_q      <= 1'b0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      div0_q        <= 1'b0;
      ctrl_mem_q    <= '0;
      rd_mem_q      <= '0;
      pc4_mem_q     <= '0;
      alu_result_q  <= '0;
      write_data1_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      is_rem_q      <= is_rem_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      div0_q        <= div0_d;
      ctrl_mem_q    <= ctrl_mem_d;
      rd_mem_q      <= rd_mem_d;
      pc4_mem_q     <= pc4_mem_d;
      alu_result_q  <= alu_result_d;
      write_data1_q <= write_data1_d;
    end
  end

  // stall is suppressed while reset is held so upstream never freezes on reset
  assign bus.stall_ex    = stall & reset_n;
  assign bus.ctrl_mem    = ctrl_mem_q;
  assign bus.rd_mem      = rd_mem_q;
  assign bus.pc4_mem     = pc4_mem_q;
  assign bus.alu_result  = alu_result_q;
  assign bus.write_data1 = write_data1_q;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32IM pipeline: operand select, single-cycle ALU/multiply, and a 32-iteration restoring divider.
- Its EX/MEM pipeline register drives the memory stage directly (ctrl_mem, rd_mem, pc4_mem, alu_result, write_data1).
- While a divide is in progress it asserts stall_ex so the upstream stages hold.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- PC_STEP, 4, increment added to pc_ex to form pc4_mem.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- valid_ex  in  1  EX holds a real instruction; 0 = bubble.
- flush_ex  in  1  synchronous kill of the EX instruction (branch redirect).
- ctrl_ex  in  5  MEM/WB control bits; forwarded unchanged to ctrl_mem.
- alu_op  in  5  operation select (encoding below).
- alu_src  in  1  1 = operand B is imm_ex, 0 = rs2_data.
- rs1_data  in  32  operand A.
- rs2_data  in  32  register operand B; also the store data.
- imm_ex  in  32  sign-extended immediate.
- pc_ex  in  32  instruction PC.
- rd_ex  in  32  destination register tag.
- ctrl_mem  out  5  registered control to MEM.
- rd_mem  out  32  registered rd.
- pc4_mem  out  32  registered pc_ex+PC_STEP.
- alu_result  out  32  registered result; MEM uses it as the address.
- write_data1  out  32  registered rs2_data (store data).
- stall_ex  out  1  combinational; 1 = hold IF/ID/EX inputs stable.

Behaviour:
- Reset (reset_n=0 at an edge): all registered outputs become 0, FSM goes to IDLE, iteration counter goes to 0.
  - stall_ex is 0 in the cycle after reset regardless of inputs until a new divide is seen.
- Operand B = alu_src ? imm_ex : rs2_data. Shift amount = B[4:0].
- alu_op encoding (all arithmetic mod 2^32):
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA (arithmetic), 8 OR, 9 AND.
  - 10 MUL (low 32 of product); 11 MULH (s×s high); 12 MULHSU (s×u high); 13 MULHU (u×u high).
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - 18 PASSB (LUI).
  - 19-31 give result 0.
- Non-divide op with valid_ex=1: single-cycle. EX/MEM register loads at the next edge; stall_ex=0.
- Divide FSM (op 14-17 with valid_ex=1):
  - IDLE: divide present → stall_ex=1; latch |A|, |B| and sign info; counter=0; go to RUN.
  - RUN: one restoring-division step per cycle; stall_ex=1; after the step with counter=31, go to DONE.
  - DONE: stall_ex=0; EX/MEM loads the divide result at this edge; go to IDLE.
  - Fixed latency: stall_ex is high for exactly 33 cycles (1 IDLE + 32 RUN). The result appears on alu_result 34 edges after the divide first appears.
- Divide result fixups are applied in DONE; latency is unchanged:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - DIV 0x80000000 / -1 gives 0x80000000; REM of the same gives 0.
  - Signed quotient is negated if the operand signs differ; signed remainder takes the dividend's sign.
- While stall_ex=1: EX/MEM loads a bubble (ctrl_mem=0, rd_mem=0, alu_result=0, write_data1=0, pc4_mem=0). Upstream must hold all EX inputs constant.
- valid_ex=0: EX/MEM loads a bubble; the FSM does not start.
- flush_ex=1 has priority over everything except reset: EX/MEM loads a bubble and the FSM returns to IDLE (aborting any divide). stall_ex=0 in that cycle.
- Reset asserted mid-divide: abort immediately; no partial result is ever emitted.
- Back-to-back divides: the second divide is seen in IDLE on the cycle after DONE and starts a fresh 33-cycle stall.

Test Plan:
- Reset: reset_n=0 for 2 edges with random inputs → all outputs 0, stall_ex=0.
- ALU:
  - ADD rs1=5, imm=-3, alu_src=1 → alu_result=2 next edge.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SLTU 1 vs 0xFFFFFFFF → 1.
  - pc_ex=0x100 → pc4_mem=0x104.
  - write_data1=rs2_data; ctrl_mem=ctrl_ex.
- Multiply:
  - MULH 0xFFFFFFFF × 0xFFFFFFFF → 0.
  - MULHU of the same operands → 0xFFFFFFFE.
  - MUL 7×-3 → 0xFFFFFFEB.
- Divide timing/value: DIV -7 / 2 → stall_ex high exactly 33 cycles; bubbles on ctrl_mem during the stall; then quotient 0xFFFFFFFD. REM -7 / 2 → 0xFFFFFFFF.
- Divide corner cases (latency unchanged):
  - DIVU 9 / 0 → 0xFFFFFFFF.
  - REM 9 / 0 → 9.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
- Abort: start a DIV, assert flush_ex at RUN cycle 10 → stall_ex=0 the same cycle, bubble emitted; a following ADD 1+1 completes with 2. Repeat using reset_n=0 mid-RUN → all outputs 0.
